car_sensor_filter: RTL
======================

# car_sensor_filter

Front-end conditioning stage for the intersection controller. It turns the raw, asynchronous, bouncy inductive-loop signal into the clean `CarDetected` level that the traffic-light FSM consumes. Processing steps:
- synchronizes the raw input;
- debounces arrivals and applies a hold-off to departures;
- emits a one-cycle arrival pulse and a stuck-sensor flag;
- optionally keeps a saturating vehicle count.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth, ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive high samples needed to declare arrival, ≥2.
- `HOLD_CYCLES`, 8: consecutive low samples needed to declare departure, ≥2.
- `STUCK_CYCLES`, 1024: continuous PRESENT cycles before fault, ≥2.
- `COUNT_W`, 8: `car_count` width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock, no other clock domains.
- `raw_sensor`  in  1  asynchronous loop-detector output.
- `count_clr`  in  1  synchronous clear of `car_count`.
- `CarDetected`  out  1  filtered presence level, to the light controller.
- `arrival_pulse`  out  1  one-cycle strobe on each accepted arrival.
- `sensor_fault`  out  1  stuck-high indication.
- `car_count`  out  `COUNT_W`  saturating arrival count.

## Operation
- `raw_sensor` passes through a `SYNC_STAGES` flop chain. Only the last stage (`sync_in`) feeds logic.
- FSM states: ABSENT, ARRIVING, PRESENT, LEAVING. There is one shared counter `cnt`.
- ABSENT:
  - `sync_in`=1 → ARRIVING, `cnt`=1.
  - Otherwise stay.
- ARRIVING:
  - `sync_in`=0 → ABSENT, `cnt`=0.
  - `sync_in`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → PRESENT, `cnt`=0.
  - Otherwise `cnt`++.
- PRESENT:
  - `sync_in`=0 → LEAVING, `cnt`=1.
  - Otherwise stay.
- LEAVING:
  - `sync_in`=1 → PRESENT, `cnt`=0. This is a re-entry, not a new arrival: no pulse, no count.
  - `sync_in`=0 and `cnt`==`HOLD_CYCLES`-1 → ABSENT.
  - Otherwise `cnt`++.
- `CarDetected` = state ∈ {PRESENT, LEAVING}. It is decoded from the state register only; there is no combinational path from any input.
- `arrival_pulse` is registered. It is 1 for exactly the first cycle after each ARRIVING→PRESENT transition.
- Stuck counter:
  - Counts cycles spent in PRESENT; cleared in every other state.
  - `sensor_fault` sets when the count reaches `STUCK_CYCLES`-1 while in PRESENT.
  - `sensor_fault` stays set through LEAVING and clears on entry to ABSENT.
  - `CarDetected` is unaffected by the fault.
- `car_count`:
  - Increments on each ARRIVING→PRESENT transition.
  - Saturates at all-ones.
  - `count_clr` has priority: simultaneous clear and arrival gives 0.

## Timing
- Reset values: sync chain 0, state ABSENT, `cnt` 0, `CarDetected` 0, `arrival_pulse` 0, `sensor_fault` 0, `car_count` 0.
- Reset asserted mid-operation forces all of the above at the next edge, from any state.
- Rise latency: count the first edge that samples `raw_sensor`=1 as edge 1. `CarDetected` and `arrival_pulse` go high after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults that is edge 6.
- Fall latency: `CarDetected` drops after edge `SYNC_STAGES`+`HOLD_CYCLES`, counted from the first low sample. With defaults that is edge 10.
- A high pulse of fewer than `DEBOUNCE_CYCLES` synchronized samples is ignored.
- A low gap of fewer than `HOLD_CYCLES` samples is bridged.
- `car_count` updates on the same edge that `arrival_pulse` rises.

## Configuration
- `CAR_SENSOR_COUNT_EN` defined: the `car_count` register and its clear/saturation logic are built.
- Undefined:
  - `car_count` is tied to 0 and `count_clr` is ignored.
  - No count flops are synthesized.
  - Port list is unchanged.
  - All other behaviour is identical.

## Structure
- Shared package `car_sensor_pkg`:
  - state enum typedef (ABSENT, ARRIVING, PRESENT, LEAVING);
  - default parameter constants;
  - a `clog2`-based width constant for `cnt` = max(`DEBOUNCE_CYCLES`, `HOLD_CYCLES`).
- One sub-module, `bit_synchronizer`:
  - parameterized by `SYNC_STAGES`;
  - synchronous reset to 0;
  - reusable for other asynchronous sensor inputs.

## Test plan
All scenarios use default parameters unless stated.
- **Reset:** hold `reset` 3 cycles with `raw_sensor` toggling → all outputs 0; state ABSENT after the first post-reset edge.
- **Clean arrival:** `raw_sensor`=1 for 12 cycles → `CarDetected` rises after edge 6; `arrival_pulse`=1 for that single cycle; `car_count`=1.
- **Glitch rejection:** `raw_sensor`=1 for 3 cycles, then 0 → `CarDetected` stays 0; no pulse; `car_count`=0.
- **Dropout bridging:**
  - While PRESENT, `raw_sensor`=0 for 5 cycles, then 1 → `CarDetected` stays 1; no pulse; count unchanged.
  - Then 0 for 12 cycles → `CarDetected` falls after edge 10.
- **Saturation and clear (`COUNT_W`=2, macro defined):**
  - 5 clean arrivals → `car_count`=3.
  - Assert `count_clr` on the edge of a 6th arrival → `car_count`=0.
  - Macro undefined → `car_count` always 0.
- **Stuck sensor (`STUCK_CYCLES`=16):**
  - `raw_sensor` held 1 → `sensor_fault` rises 16 cycles after PRESENT entry.
  - Release → fault held through LEAVING; clears when ABSENT.
  - `reset` asserted mid-LEAVING → all outputs 0 the next cycle.

Source files
------------

// File: rtl/car_sensor_pkg.sv
// Shared types and defaults for the loop-detector conditioning path.
// State enum, default parameters and the shared-counter width helper.
package car_sensor_pkg;

    typedef enum logic [1:0] {
        ABSENT,
        ARRIVING,
        PRESENT,
        LEAVING
    } sensorState_t;

    localparam int DefSyncStages = 2;
    localparam int DefDebounce   = 4;
    localparam int DefHold       = 8;
    localparam int DefStuck      = 1024;
    localparam int DefCountW     = 8;

    function automatic int cntWidth(input int debounce, input int hold);
        return $clog2(debounce > hold ? debounce : hold);
    endfunction

    localparam int DefCntW = cntWidth(DefDebounce, DefHold);

endpackage

// File: rtl/car_sensor_filter_if.sv
// Sensor-side bundle: raw loop input and count clear toward the filter,
// filtered presence, arrival strobe, fault flag and vehicle count back.
interface car_sensor_filter_if #(
    parameter int COUNT_W = 8
);
    logic               raw_sensor;
    logic               count_clr;
    logic               CarDetected;
    logic               arrival_pulse;
    logic               sensor_fault;
    logic [COUNT_W-1:0] car_count;

    modport master (
        output raw_sensor, count_clr,
        input  CarDetected, arrival_pulse, sensor_fault, car_count
    );

    modport slave (
        input  raw_sensor, count_clr,
        output CarDetected, arrival_pulse, sensor_fault, car_count
    );
endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Reusable for any asynchronous sensor input; resets to 0.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic asyncIn,
    output logic syncOut
);
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], asyncIn};
        end
    end

    assign syncOut = chain[SYNC_STAGES-1];
endmodule

// File: rtl/car_sensor_filter.sv
// Debounce / hold-off filter for the inductive loop detector.
// Define CAR_SENSOR_COUNT_EN to build the saturating car_count register.
module car_sensor_filter
    import car_sensor_pkg::*;
#(
    parameter int SYNC_STAGES     = DefSyncStages,
    parameter int DEBOUNCE_CYCLES = DefDebounce,
    parameter int HOLD_CYCLES     = DefHold,
    parameter int STUCK_CYCLES    = DefStuck,
    parameter int COUNT_W         = DefCountW
) (
    input  logic                clk,
    input  logic                reset,
    car_sensor_filter_if.slave  bus
);
    localparam int CntW   = cntWidth(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam int StuckW = $clog2(STUCK_CYCLES);

    localparam logic [CntW-1:0]   DebLast   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0]   HoldLast  = CntW'(HOLD_CYCLES - 1);
    localparam logic [StuckW-1:0] StuckLast = StuckW'(STUCK_CYCLES - 1);

    logic              syncIn;
    sensorState_t      state;
    logic [CntW-1:0]   cnt;
    logic [StuckW-1:0] stuckCnt;
    logic              pulse;
    logic              fault;
    logic              arrive;

    bit_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) uSync (
        .clk     (clk),
        .reset   (reset),
        .asyncIn (bus.raw_sensor),
        .syncOut (syncIn)
    );

    assign arrive = (state == ARRIVING) && syncIn && (cnt == DebLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ABSENT;
            cnt      <= '0;
            stuckCnt <= '0;
            pulse    <= 1'b0;
            fault    <= 1'b0;
        end else begin
            pulse <= arrive;
            unique case (state)
                ABSENT: begin
                    if (syncIn) begin
                        state <= ARRIVING;
                        cnt   <= CntW'(1);
                    end
                end
                ARRIVING: begin
                    if (!syncIn) begin
                        state <= ABSENT;
                        cnt   <= '0;
                    end else if (cnt == DebLast) begin
                        state <= PRESENT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                PRESENT: begin
                    if (!syncIn) begin
                        state <= LEAVING;
                        cnt   <= CntW'(1);
                    end
                end
                LEAVING: begin
                    // a return to high is the same vehicle, not a new arrival
                    if (syncIn) begin
                        state <= PRESENT;
                        cnt   <= '0;
                    end else if (cnt == HoldLast) begin
                        state <= ABSENT;
                        cnt   <= '0;
                        fault <= 1'b0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
            endcase

            if (state == PRESENT) begin
                if (stuckCnt == StuckLast) begin
                    fault <= 1'b1;
                end else begin
                    stuckCnt <= stuckCnt + StuckW'(1);
                end
            end else begin
                stuckCnt <= '0;
            end
        end
    end

    assign bus.CarDetected   = (state == PRESENT) || (state == LEAVING);
    assign bus.arrival_pulse = pulse;
    assign bus.sensor_fault  = fault;

`ifdef CAR_SENSOR_COUNT_EN
    logic [COUNT_W-1:0] countQ;

    always_ff @(posedge clk) begin
        if (reset || bus.count_clr) begin
            countQ <= '0;
        end else if (arrive && (countQ != '1)) begin
            countQ <= countQ + COUNT_W'(1);
        end
    end

    assign bus.car_count = countQ;
`else
    logic unusedCountClr;

    assign unusedCountClr = bus.count_clr;
    assign bus.car_count  = '0;
`endif

endmodule
